// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: receiver FSM states, frame shape and bit-period helper.
// Also used by the matching transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Clocks per serial bit (integer division; callers require a result >= 4).
  function automatic int unsigned uart_tr(input int unsigned f, input int unsigned baud);
    return f / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter, so idle-high lines do not see a false edge out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: emits each good byte on ascii_char with a one-cycle char_valid strobe.
// A frame whose stop bit is low raises frame_error instead and is not forwarded.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned freq         = 200,
  parameter int unsigned UART_RX_BAUD = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned TR   = uart_tr(freq, UART_RX_BAUD);
  localparam int unsigned HALF = TR / 2;
  localparam int unsigned CW   = (TR > 1) ? $clog2(TR) : 1;

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  ascii_q, ascii_d;
  logic        cv_q, cv_d;
  logic        fe_q, fe_d;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      ascii_q <= '0;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ascii_q <= ascii_d;
      cv_q    <= cv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    ascii_d = ascii_q;
    cv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CW'(TR - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // Sampling at mid stop bit returns to IDLE early enough to catch a back-to-back start edge.
        if (cnt_q == CW'(TR - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            ascii_d = sh_q;
            cv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ascii_char  = ascii_q;
  assign char_valid  = cv_q;
  assign frame_error = fe_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed self-checking bench for uart_rx_byte at TR=10 (freq 200, baud 20).
module tb_uart_rx_byte;

  localparam int TR = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       frame_error;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0;
  int cv_count = 0;
  int fe_count = 0;
  int both_count = 0;
  logic [7:0] cv_log[$];
  int cv_time[$];
  int start_cyc;

  uart_rx_byte #(.freq(200), .UART_RX_BAUD(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .ascii_char  (ascii_char),
    .char_valid  (char_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (char_valid) begin
      cv_count = cv_count + 1;
      cv_log.push_back(ascii_char);
      cv_time.push_back(cyc);
    end
    if (frame_error) fe_count = fe_count + 1;
    if (char_valid && frame_error) both_count = both_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    start_cyc = cyc;
    hold(TR);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(TR);
    end
    rx = stop_bit;
    hold(TR);
  endtask

  initial begin
    int base;
    logic [7:0] exp_seq [5];
    logic [7:0] b36;
    exp_seq[0] = 8'h31; exp_seq[1] = 8'h32; exp_seq[2] = 8'h33;
    exp_seq[3] = 8'h2B; exp_seq[4] = 8'h58;

    // 1: reset and idle line
    hold(3);
    chk("rst_ascii", ascii_char, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cv", char_valid, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    rst = 1'b0;
    hold(100);
    chk("idle_cv_count", cv_count, 0);
    chk("idle_fe_count", fe_count, 0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ascii", ascii_char, 8'h00);

    // 2: single byte 0x31 and its latency
    send_frame(8'h31, 1'b1);
    hold(20);
    chk("b31_count", cv_count, 1);
    chk("b31_ascii", ascii_char, 8'h31);
    chk("b31_fe", fe_count, 0);
    chk("b31_latency", cv_time[0] - start_cyc, 98);
    chk("b31_busy", busy, 1'b0);

    // 3: "123+X" back-to-back
    base = cv_count;
    for (int k = 0; k < 5; k++) send_frame(exp_seq[k], 1'b1);
    hold(20);
    chk("b2b_count", cv_count, base + 5);
    for (int k = 0; k < 5; k++) begin
      if (cv_log.size() > base + k) chk($sformatf("b2b_val%0d", k), cv_log[base + k], exp_seq[k]);
      else chk($sformatf("b2b_missing%0d", k), 0, 1);
    end
    for (int k = 1; k < 5; k++) begin
      if (cv_time.size() > base + k)
        chk($sformatf("b2b_gap%0d", k), cv_time[base + k] - cv_time[base + k - 1], 100);
    end
    chk("b2b_fe", fe_count, 0);

    // 4: 3-clock glitch, then 0x41
    base = cv_count;
    rx = 1'b0;
    hold(3);
    rx = 1'b1;
    hold(20);
    chk("glitch_cv", cv_count, base);
    chk("glitch_busy", busy, 1'b0);
    send_frame(8'h41, 1'b1);
    hold(20);
    chk("b41_count", cv_count, base + 1);
    chk("b41_ascii", ascii_char, 8'h41);
    chk("glitch_fe", fe_count, 0);

    // 5: 0x00 with low stop bit and line break, then 0x2A
    base = cv_count;
    send_frame(8'h00, 1'b0);
    hold(30);
    chk("brk_busy", busy, 1'b1);
    rx = 1'b1;
    hold(20);
    chk("brk_fe_count", fe_count, 1);
    chk("brk_cv", cv_count, base);
    chk("brk_ascii", ascii_char, 8'h41);
    chk("brk_idle", busy, 1'b0);
    send_frame(8'h2A, 1'b1);
    hold(20);
    chk("b2a_count", cv_count, base + 1);
    chk("b2a_ascii", ascii_char, 8'h2A);
    chk("b2a_fe", fe_count, 1);

    // 6: reset in the middle of data bit 4 of 0x36
    base = cv_count;
    b36 = 8'h36;
    rx = 1'b0;
    hold(TR);
    for (int i = 0; i < 4; i++) begin
      rx = b36[i];
      hold(TR);
    end
    rx = b36[4];
    hold(5);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("midrst_ascii", ascii_char, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cv", char_valid, 1'b0);
    hold(5);
    rst = 1'b0;
    hold(20);
    chk("postrst_cv", cv_count, base);
    send_frame(8'h36, 1'b1);
    hold(20);
    chk("b36_count", cv_count, base + 1);
    chk("b36_ascii", ascii_char, 8'h36);

    chk("never_both", both_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: observed no completion, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART 8N1 serial receiver producing the ascii_char / char_valid byte stream consumed by the sequence checker (verify).
- Sits between the board RX pin and the checker.
- Replaces the bench-driven character stream with real serial input.
- Each received byte is presented on ascii_char with a one-cycle char_valid strobe.
- Malformed frames are flagged on frame_error and are not forwarded.

Parameters:
freq, 200, system clock frequency (same unit as the baud parameter).
UART_RX_BAUD, 20, serial bit rate.
(derived localparam) TR = freq/UART_RX_BAUD, clocks per bit; must be >= 4, integer division.
(derived localparam) HALF = TR/2, start-bit mid-sample offset.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous, active-high reset.
rx  input  1  serial line, idle high, asynchronous to clk.
ascii_char  output  8  last correctly received byte.
char_valid  output  1  one-cycle strobe: ascii_char updated this cycle.
frame_error  output  1  one-cycle strobe: stop bit sampled low.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - ascii_char=0, char_valid=0, frame_error=0, busy=0.
  - State=IDLE, counters 0.
  - Synchronizer flops = 1.
- Input path: rx passes through 2-flop synchronizer → rx_s (2-cycle latency). All decisions use rx_s only.
- One counter cnt (width clog2(TR)) and bit index idx (0..7). Shift register sh[7:0] fills LSB-first: sh <= {rx_s, sh[7:1]}.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 → START, cnt=0. Call this cycle t0.
- START:
  - At cnt==HALF-1 (cycle t0+HALF), sample rx_s.
  - rx_s==0 → DATA, cnt=0, idx=0.
  - rx_s==1 → glitch, return to IDLE, no strobe.
- DATA:
  - At cnt==TR-1, sample rx_s into sh, cnt=0.
  - Bit i is sampled at cycle t0+HALF+TR*(i+1).
  - After idx==7 sampled → STOP.
- STOP:
  - At cnt==TR-1 (cycle t0+HALF+9*TR), sample rx_s.
  - rx_s==1: ascii_char<=sh, char_valid=1 next cycle, → IDLE.
  - rx_s==0: frame_error=1 next cycle, ascii_char unchanged, → WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then → IDLE. Covers a line break, so no false start bits are decoded.
- Strobe rules:
  - char_valid and frame_error are registered and high for exactly one cycle.
  - They are never asserted together.
  - Both are 0 in every other cycle.
- ascii_char holds its value between strobes. Downstream may sample it at any time after char_valid.
- Back-to-back frames (no idle gap):
  - The FSM is back in IDLE HALF cycles before the nominal end of the stop bit.
  - It must detect the next start edge with no lost frame.
  - Frame-to-frame char_valid spacing = 10*TR cycles.
- Value 0x00 is a legal byte and is forwarded like any other.
- rst mid-frame:
  - Frame is abandoned, no strobe.
  - The receiver resynchronises on the next falling edge after rst deasserts.
- Tolerance: the mid-bit sample must accept a transmitter baud deviation of ±3% at TR=10.

Decomposition:
- Shared package (uart_pkg):
  - State enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - Helper function computing TR from freq/baud, reused by the matching uart_tx that verify drives via UART_TX_baud.
- One sub-module: sync2 (parameterised-reset 2-flop synchronizer), reusable for other async inputs.
- The FSM, counters and shift register stay in uart_rx_byte.

Test Plan:
1. Reset with rx=1, then hold 100 clocks → all outputs 0, busy=0, no strobes.
2. TR=10, send 0x31 ('1') 8N1 → exactly one char_valid pulse ~95 cycles after the start edge (plus 2 sync), ascii_char=8'h31, frame_error stays 0.
3. Send "123+X" back-to-back with no idle gap → five char_valid pulses 100 cycles apart; values 31,32,33,2B,58 in order.
4. rx low for 3 clocks then high, followed by a valid 0x41 frame → no strobe for the glitch; one char_valid with ascii_char=8'h41.
5. Send 0x00 with stop bit low, hold line low 30 clocks, release, then send 0x2A → one frame_error pulse, no char_valid, ascii_char keeps the prior value; then char_valid with 8'h2A.
6. Assert rst during data bit 4 of 0x36, release, send 0x36 again → outputs 0 immediately at rst; exactly one char_valid with 8'h36 afterwards.
